dsi_cmd_tx_packetizer: RTL

Transmit-side counterpart of the command-mode receive path: turns a stream of packed RGB888 line words into MIPI DSI DCS long-write packets (data type 0x39, word count X_RES*3+1, first payload byte 0x2C for the first line of a frame and 0x3C for every later line). It sits between a line FIFO (first-word-fall-through) and the DSI TX packet interface. Frames start on the panel TE rising edge. The block also issues a DCS short write "display off" (0x05 / 0x28) on request.

---
 rtl/dsi_cmd_tx_packetizer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/dsi_cmd_tx_packetizer.sv
// DSI command-mode TX packetizer: RGB888 line words become DCS long writes,
// one frame per TE edge, plus a display-off short write on request.
module dsi_cmd_tx_packetizer #(
    parameter int         X_RES = 1080,
    parameter int         Y_RES = 2340,
    parameter logic [1:0] VC    = 2'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        te,
    input  logic        disp_off_req,
    input  logic [31:0] src_data,
    input  logic        src_valid,
    output logic        src_ready,
    input  logic        src_line_avail,
    output logic [23:0] tx_cmd,
    output logic        tx_cmd_valid,
    input  logic        tx_cmd_ready,
    output logic [31:0] tx_payload,
    output logic        tx_payload_valid,
    output logic        tx_payload_valid_last,
    input  logic        tx_payload_ready,
    output logic        frame_busy,
    output logic        frame_done,
    output logic        underrun,
    output logic [11:0] line_cnt
);
    localparam int WPL = X_RES * 3 / 4;
    localparam int WCW = $clog2(WPL + 1);
    localparam logic [23:0] LONG_HDR = {16'(X_RES * 3 + 1), VC, 6'h39};
    localparam logic [23:0] OFF_CMD  = {16'h0028, VC, 6'h05};

    typedef enum logic [2:0] {IDLE, OFF_HDR, HDR, PLD, TAIL} state_t;

    state_t           state, state_n;
    logic             te_s1, te_s2, te_d, te_rise;
    logic             off_pend, off_pend_n;
    logic [7:0]       carry, carry_n;
    logic [WCW-1:0]   word_cnt, word_cnt_n;
    logic [23:0]      cmd_n;
    logic             cmd_valid_n, busy_n, done_n, underrun_n;
    logic [11:0]      line_n;

    assign te_rise = te_s2 & ~te_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            te_s1        <= 1'b0;
            te_s2        <= 1'b0;
            te_d         <= 1'b0;
            off_pend     <= 1'b0;
            carry        <= 8'h00;
            word_cnt     <= '0;
            tx_cmd       <= 24'h0;
            tx_cmd_valid <= 1'b0;
            line_cnt     <= 12'h0;
            frame_busy   <= 1'b0;
            frame_done   <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            state        <= state_n;
            te_s1        <= te;
            te_s2        <= te_s1;
            te_d         <= te_s2;
            off_pend     <= off_pend_n;
            carry        <= carry_n;
            word_cnt     <= word_cnt_n;
            tx_cmd       <= cmd_n;
            tx_cmd_valid <= cmd_valid_n;
            line_cnt     <= line_n;
            frame_busy   <= busy_n;
            frame_done   <= done_n;
            underrun     <= underrun_n;
        end
    end

    always_comb begin
        state_n               = state;
        off_pend_n            = off_pend | disp_off_req;
        carry_n               = carry;
        word_cnt_n            = word_cnt;
        cmd_n                 = tx_cmd;
        cmd_valid_n           = tx_cmd_valid;
        line_n                = line_cnt;
        busy_n                = frame_busy;
        done_n                = 1'b0;
        underrun_n            = underrun;
        tx_payload            = 32'h0;
        tx_payload_valid      = 1'b0;
        tx_payload_valid_last = 1'b0;
        src_ready             = 1'b0;

        unique case (state)
            IDLE: begin
                // A pending display-off wins; a TE edge in that cycle is lost.
                if (off_pend || disp_off_req) begin
                    state_n     = OFF_HDR;
                    cmd_n       = OFF_CMD;
                    cmd_valid_n = 1'b1;
                end else if (te_rise && enable) begin
                    state_n     = HDR;
                    line_n      = 12'h0;
                    busy_n      = 1'b1;
                    cmd_n       = LONG_HDR;
                    cmd_valid_n = src_line_avail;
                end
            end
            OFF_HDR: begin
                if (tx_cmd_ready) begin
                    state_n     = IDLE;
                    cmd_valid_n = 1'b0;
                    off_pend_n  = disp_off_req;
                end
            end
            HDR: begin
                if (!tx_cmd_valid) begin
                    cmd_n       = LONG_HDR;
                    cmd_valid_n = src_line_avail;
                end else if (tx_cmd_ready) begin
                    state_n     = PLD;
                    cmd_valid_n = 1'b0;
                    carry_n     = (line_cnt == 12'h0) ? 8'h2C : 8'h3C;
                    word_cnt_n  = '0;
                end
            end
            PLD: begin
                tx_payload_valid = src_valid;
                src_ready        = tx_payload_ready;
                if (src_valid) tx_payload = {src_data[23:0], carry};
                else           underrun_n = 1'b1;
                if (src_valid && tx_payload_ready) begin
                    carry_n    = src_data[31:24];
                    word_cnt_n = word_cnt + 1'b1;
                    if (word_cnt == WCW'(WPL - 1)) state_n = TAIL;
                end
            end
            TAIL: begin
                tx_payload            = {24'h0, carry};
                tx_payload_valid      = 1'b1;
                tx_payload_valid_last = 1'b1;
                if (tx_payload_ready) begin
                    if (line_cnt == 12'(Y_RES - 1)) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                    end else begin
                        state_n     = HDR;
                        line_n      = line_cnt + 12'h1;
                        cmd_n       = LONG_HDR;
                        cmd_valid_n = src_line_avail;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule
